// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned div_calc(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream leaving the receiver FIFO: data/valid/ready handshake plus occupancy.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [FW-1:0]        fill;

  modport master (output out_data, output out_valid, output fill, input out_ready);
  modport slave  (input out_data, input out_valid, input fill, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty and occupancy; shared by the UART RX and TX paths.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign fill    = wptr - rptr;
  assign full    = (fill == DEPTH_CNT);
  assign empty   = (fill == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + DATA_BITS LSB-first + stop) feeding an output FIFO.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD = 1'b0
`endif
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            rx,
  uart_rx_fifo_if.master  out,
  output logic            frame_err,
  output logic            overrun
);
  localparam int unsigned DIV  = div_calc(CLK_HZ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned FW   = $clog2(FIFO_DEPTH) + 1;

  rx_state_t            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bitcnt, bitcnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 rx_m, rx_s;
  logic                 push;
  logic                 ferr_d, ferr_q;
  logic                 ovr_d, ovr_q;
  logic                 fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_fill;
  logic [DATA_BITS-1:0] fifo_dout;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_d;
  logic                 par_ok;
  assign par_ok = ((^{shift, par_bit}) == PARITY_ODD);
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      bitcnt <= bitcnt_d;
      shift  <= shift_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    bitcnt_d = bitcnt;
    shift_d  = shift;
    push     = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_bit;
`endif
    unique case (state)
      IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_d    = '0;
          shift_d  = {rx_s, shift[DATA_BITS-1:1]};
          bitcnt_d = bitcnt + 1'b1;
          if (bitcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt == CW'(DIV - 1)) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (!par_ok) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Overrun only when the push is blocked: a same-cycle pop lets the FIFO absorb the byte.
  assign ovr_d = push && fifo_full && !(out.out_ready && !fifo_empty);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (push),
    .din   (shift),
    .pop   (out.out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fifo_fill)
  );

  assign out.out_data  = fifo_dout;
  assign out.out_valid = !fifo_empty;
  assign out.fill      = fifo_fill;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at DIV=10, 8 data bits, 4-entry FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic frame_err;
  logic overrun;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int valid_cycles = 0;
  int max_fill = 0;
  logic ferr_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) u ();

  uart_rx_fifo #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .rx        (rx),
    .out       (u),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every accepted byte, tallies pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (u.out_valid) valid_cycles++;
      if (int'(u.fill) > max_fill) max_fill = int'(u.fill);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) begin
        errors++;
        $display("FAIL pulse_overlap: frame_err=%0b overrun=%0b required not both", frame_err, overrun);
      end
      if ((frame_err && ferr_prev) || (overrun && ovr_prev)) begin
        errors++;
        $display("FAIL pulse_width: frame_err/overrun high two cycles, required one");
      end
      ferr_prev = frame_err;
      ovr_prev  = overrun;
      if (u.out_valid && u.out_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_data: got %02h with no byte expected", u.out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (u.out_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %02h required %02h", u.out_data, e);
          end
        end
      end
    end else begin
      ferr_prev = 1'b0;
      ovr_prev  = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par, input bit pop_at_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) drive_bit(1'b1);
`endif
    rx = stop;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (pop_at_stop && k == 7) u.out_ready = 1'b1;
      if (pop_at_stop && k == 8) u.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx = 1'b1;
    u.out_ready = 1'b0;
    idle(3);
    checks++; if (u.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", u.out_valid); end
    checks++; if (u.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h required 00", u.out_data); end
    checks++; if (u.fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d required 0", u.fill); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %0b%0b required 00", frame_err, overrun); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dut.state, IDLE); end
    rstn = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int p0;
    p0 = pops;
    u.out_ready = 1'b1;
    valid_cycles = 0;
    max_fill = 0;
    exp_q.push_back(8'h55); send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'hA3); send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    idle(5);
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL basic_pops: got %0d required 2", pops - p0); end
    checks++; if (valid_cycles !== 2) begin errors++; $display("FAIL basic_valid_cycles: got %0d required 2", valid_cycles); end
    checks++; if (max_fill > 1) begin errors++; $display("FAIL basic_fill: got %0d required <=1", max_fill); end
  endtask

  task automatic test_glitch();
    int p0, f0;
    p0 = pops; f0 = ferr_cnt;
    rx = 1'b0; idle(3); rx = 1'b1;
    idle(20);
    checks++; if (pops - p0 !== 0 || u.out_valid !== 1'b0) begin errors++; $display("FAIL glitch_push: got pops=%0d valid=%0b required 0/0", pops - p0, u.out_valid); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d required 0", ferr_cnt - f0); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d required %0d", dut.state, IDLE); end
  endtask

  task automatic test_frame_err();
    int p0, f0;
    p0 = pops; f0 = ferr_cnt;
    u.out_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(40);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d required 1", ferr_cnt - f0); end
    checks++; if (pops - p0 !== 0) begin errors++; $display("FAIL ferr_push: got %0d required 0", pops - p0); end
    checks++; if (dut.state !== BREAK) begin errors++; $display("FAIL ferr_state: got %0d required %0d", dut.state, BREAK); end
    rx = 1'b1;
    idle(5);
    exp_q.push_back(8'h7E); send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    idle(5);
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL ferr_recover: got %0d pops required 1", pops - p0); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_extra: got %0d required 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int p0, o0;
    p0 = pops; o0 = ovr_cnt;
    u.out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1, 1'b0, 1'b0);
      if (v == 4) begin
        checks++; if (u.fill !== 3'd4) begin errors++; $display("FAIL ovr_fill4: got %0d required 4", u.fill); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_early: got %0d required 0", ovr_cnt - o0); end
      end
    end
    idle(2);
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d required 1", ovr_cnt - o0); end
    checks++; if (u.fill !== 3'd4) begin errors++; $display("FAIL ovr_fill: got %0d required 4", u.fill); end
    u.out_ready = 1'b1;
    idle(8);
    u.out_ready = 1'b0;
    checks++; if (pops - p0 !== 4 || u.fill !== 3'd0) begin errors++; $display("FAIL ovr_drain: got pops=%0d fill=%0d required 4/0", pops - p0, u.fill); end
  endtask

  task automatic test_full_pop();
    int p0, o0;
    p0 = pops; o0 = ovr_cnt;
    u.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1, 1'b0, 1'b0);
    end
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1);
    idle(2);
    checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL fullpop_ovr: got %0d required 0", ovr_cnt - o0); end
    checks++; if (u.fill !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d required 4", u.fill); end
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL fullpop_pop: got %0d required 1", pops - p0); end
    u.out_ready = 1'b1;
    idle(8);
    checks++; if (pops - p0 !== 5 || exp_q.size() !== 0) begin errors++; $display("FAIL fullpop_drain: got pops=%0d left=%0d required 5/0", pops - p0, exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int p0, f0;
    logic [7:0] d;
    d = 8'hC9;
    u.out_ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    checks++; if (u.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0b required 1", u.out_valid); end
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    idle(4);
    #2 rstn = 1'b0;
    #1;
    checks++; if (u.out_valid !== 1'b0 || u.fill !== 3'd0) begin errors++; $display("FAIL rst_async: got valid=%0b fill=%0d required 0/0", u.out_valid, u.fill); end
    checks++; if (u.out_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_async_out: got data=%02h fe=%0b ov=%0b required 00/0/0", u.out_data, frame_err, overrun); end
    exp_q.delete();
    idle(2);
    rx = 1'b1;
    rstn = 1'b1;
    p0 = pops; f0 = ferr_cnt;
    idle(60);
    checks++; if (ferr_cnt - f0 !== 0 || u.out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort: got fe=%0d valid=%0b required 0/0", ferr_cnt - f0, u.out_valid); end
    u.out_ready = 1'b1;
    exp_q.push_back(8'hC9); send_frame(8'hC9, 1'b1, 1'b0, 1'b0);
    idle(5);
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL rst_recover: got %0d pops required 1", pops - p0); end
`ifdef UART_RX_PARITY_EN
    send_frame(8'hC9, 1'b1, 1'b1, 1'b0);
    idle(5);
    checks++; if (ferr_cnt - f0 !== 1 || pops - p0 !== 1) begin errors++; $display("FAIL parity_err: got fe=%0d pops=%0d required 1/1", ferr_cnt - f0, pops - p0); end
`endif
  endtask

  initial begin
    u.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: got %0d required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
